// File: rtl/prism_sp_rx_frame_reader.sv
// ---------------------------------------------------------------------------
// prism_sp_rx_frame_reader
//
// Purpose: drains received frames out of two first-word-fall-through FIFOs.
// The meta FIFO holds one descriptor per frame: the length in bytes and an
// opaque status field. The data FIFO holds the packed frame bytes. The block
// emits each frame as an AXI-Stream burst. m_tuser carries the frame status,
// and m_tkeep masks the unused bytes of the final beat.
//
// Optional feature: define PRISM_SP_RX_READER_STATS_EN to add three 32-bit
// counters (stats_nframes, stats_nbytes, stats_nzero).
//
// Ports:
//   clock, resetn      sole clock, asynchronous active-low reset
//   meta_empty         meta FIFO empty (FWFT)
//   meta_rd_data       descriptor {status[31:LEN_WIDTH], len[LEN_WIDTH-1:0]}
//   meta_rd_en         pops one descriptor
//   data_empty         data FIFO empty (FWFT)
//   data_rd_data       packed frame bytes, byte 0 in bits [7:0]
//   data_rd_en         pops one data word
//   m_tdata/m_tkeep/m_tuser/m_tlast/m_tvalid/m_tready   AXI-Stream master
//
// Handshake: a beat moves when m_tvalid & m_tready are both high at a rising
// clock edge. Once m_tvalid is raised, the beat and its sideband fields are
// held until that happens. A FIFO word leaves when its rd_en is high at a
// rising edge; rd_en is only raised while the matching empty flag is low.
// ---------------------------------------------------------------------------
module prism_sp_rx_frame_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 13
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    meta_empty,
    input  logic [31:0]             meta_rd_data,
    output logic                    meta_rd_en,
    input  logic                    data_empty,
    input  logic [DATA_WIDTH-1:0]   data_rd_data,
    output logic                    data_rd_en,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tkeep,
    output logic [31-LEN_WIDTH:0]   m_tuser,
    output logic                    m_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready
`ifdef PRISM_SP_RX_READER_STATS_EN
    ,
    output logic [31:0]             stats_nframes,
    output logic [31:0]             stats_nbytes,
    output logic [31:0]             stats_nzero
`endif
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int UW    = 32 - LEN_WIDTH;
    localparam logic [LEN_WIDTH:0] BYTES_L    = (LEN_WIDTH + 1)'(BYTES);
    localparam logic [LEN_WIDTH:0] BYTES_M1_L = (LEN_WIDTH + 1)'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [UW-1:0]         status_q, status_d;
    logic [LEN_WIDTH-1:0]  words_left_q, words_left_d;
    logic [BYTES-1:0]      last_keep_q, last_keep_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [BYTES-1:0]      out_keep_q, out_keep_d;
    logic [UW-1:0]         out_user_q, out_user_d;
    logic                  out_last_q, out_last_d;
    logic                  out_valid_q, out_valid_d;
`ifdef PRISM_SP_RX_READER_STATS_EN
    logic [31:0]           nframes_q, nframes_d;
    logic [31:0]           nbytes_q, nbytes_d;
    logic [31:0]           nzero_q, nzero_d;
`endif

    logic                  meta_pop;
    logic                  data_pop;
    logic                  accept;
    logic [LEN_WIDTH:0]    len_ext;
    logic [LEN_WIDTH:0]    len_round;
    logic [LEN_WIDTH:0]    words_calc;
    logic [LEN_WIDTH:0]    len_rem;
    logic [BYTES-1:0]      keep_calc;

    // Word count and tail mask of the latched length. One extra bit keeps
    // the round-up addition from overflowing at the largest length.
    always_comb begin
        len_ext    = {1'b0, len_q};
        len_round  = len_ext + BYTES_M1_L;
        words_calc = len_round / BYTES_L;
        len_rem    = len_ext % BYTES_L;
        keep_calc  = '0;
        for (int i = 0; i < BYTES; i++) begin
            keep_calc[i] = (len_rem == '0) || ((LEN_WIDTH + 1)'(i) < len_rem);
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        status_d     = status_q;
        words_left_d = words_left_q;
        last_keep_d  = last_keep_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_user_d   = out_user_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;
`ifdef PRISM_SP_RX_READER_STATS_EN
        nframes_d    = nframes_q;
        nbytes_d     = nbytes_q;
        nzero_d      = nzero_q;
`endif
        meta_pop     = 1'b0;
        data_pop     = 1'b0;
        accept       = out_valid_q & m_tready;

        case (state_q)
            IDLE: begin
                if (!meta_empty) begin
                    meta_pop = 1'b1;
                    len_d    = meta_rd_data[LEN_WIDTH-1:0];
                    status_d = meta_rd_data[31:LEN_WIDTH];
                    state_d  = LOAD;
                end
            end

            LOAD: begin
                words_left_d = words_calc[LEN_WIDTH-1:0];
                last_keep_d  = keep_calc;
                if (len_q == '0) begin
                    state_d = IDLE;
`ifdef PRISM_SP_RX_READER_STATS_EN
                    nzero_d = nzero_q + 32'd1;
`endif
                end else begin
                    state_d = STREAM;
                end
            end

            STREAM: begin
                if (accept) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = IDLE;
`ifdef PRISM_SP_RX_READER_STATS_EN
                        nframes_d = nframes_q + 32'd1;
                        nbytes_d  = nbytes_q + 32'(len_q);
`endif
                    end
                end
                // The output register refills in the same cycle it drains,
                // which sustains one beat per clock. When the last beat sits
                // in the register words_left is already zero, so a pop never
                // coincides with the end-of-frame acceptance.
                if (!data_empty && (words_left_q != '0) && (!out_valid_q || accept)) begin
                    data_pop     = 1'b1;
                    out_data_d   = data_rd_data;
                    out_user_d   = status_q;
                    out_valid_d  = 1'b1;
                    out_last_d   = (words_left_q == LEN_WIDTH'(1));
                    out_keep_d   = (words_left_q == LEN_WIDTH'(1)) ? last_keep_q : '1;
                    words_left_d = words_left_q - LEN_WIDTH'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            len_q        <= '0;
            status_q     <= '0;
            words_left_q <= '0;
            last_keep_q  <= '0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_user_q   <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
`ifdef PRISM_SP_RX_READER_STATS_EN
            nframes_q    <= '0;
            nbytes_q     <= '0;
            nzero_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            status_q     <= status_d;
            words_left_q <= words_left_d;
            last_keep_q  <= last_keep_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_user_q   <= out_user_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
`ifdef PRISM_SP_RX_READER_STATS_EN
            nframes_q    <= nframes_d;
            nbytes_q     <= nbytes_d;
            nzero_q      <= nzero_d;
`endif
        end
    end

    // The state register already reads IDLE during reset, but IDLE would pop
    // a waiting descriptor combinationally. Gating with resetn keeps both
    // pop strobes low for the whole reset window.
    assign meta_rd_en = meta_pop & resetn;
    assign data_rd_en = data_pop & resetn;

    assign m_tdata  = out_data_q;
    assign m_tkeep  = out_keep_q;
    assign m_tuser  = out_user_q;
    assign m_tlast  = out_last_q;
    assign m_tvalid = out_valid_q;

`ifdef PRISM_SP_RX_READER_STATS_EN
    assign stats_nframes = nframes_q;
    assign stats_nbytes  = nbytes_q;
    assign stats_nzero   = nzero_q;
`endif

endmodule

// File: tb/tb_prism_sp_rx_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_prism_sp_rx_frame_reader
//
// Directed bench for prism_sp_rx_frame_reader (DATA_WIDTH=32, LEN_WIDTH=13).
// Two array-backed FWFT FIFO models feed the block. push_frame writes the
// data words and the descriptor, and queues the beats the block must emit.
// A negedge monitor compares every accepted beat against that queue. It also
// checks that a stalled beat stays stable and that no pop is raised on an
// empty FIFO.
// ---------------------------------------------------------------------------
module tb_prism_sp_rx_frame_reader;
  localparam int DW = 32;
  localparam int LW = 13;
  localparam int UW = 32 - LW;
  localparam int BV = DW + DW / 8 + 1 + UW;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          meta_empty;
  logic [31:0]   meta_rd_data;
  logic          meta_rd_en;
  logic          data_empty;
  logic [DW-1:0] data_rd_data;
  logic          data_rd_en;
  logic [DW-1:0] m_tdata;
  logic [3:0]    m_tkeep;
  logic [UW-1:0] m_tuser;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
`ifdef PRISM_SP_RX_READER_STATS_EN
  logic [31:0]   stats_nframes;
  logic [31:0]   stats_nbytes;
  logic [31:0]   stats_nzero;
`endif

  int n_cmp = 0;
  int n_err = 0;

  prism_sp_rx_frame_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .meta_empty   (meta_empty),
    .meta_rd_data (meta_rd_data),
    .meta_rd_en   (meta_rd_en),
    .data_empty   (data_empty),
    .data_rd_data (data_rd_data),
    .data_rd_en   (data_rd_en),
    .m_tdata      (m_tdata),
    .m_tkeep      (m_tkeep),
    .m_tuser      (m_tuser),
    .m_tlast      (m_tlast),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready)
`ifdef PRISM_SP_RX_READER_STATS_EN
    ,
    .stats_nframes(stats_nframes),
    .stats_nbytes (stats_nbytes),
    .stats_nzero  (stats_nzero)
`endif
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $error("FAIL %s", tag);
    end
  endtask

  // ---------------- FIFO models ----------------
  logic [31:0]   mmem [0:255];
  logic [DW-1:0] dmem [0:1023];
  int   mwr = 0, mrd = 0, dwr = 0, drd = 0, pops = 0;
  logic hold_empty = 1'b0;
  logic flush = 1'b0;

  assign meta_empty   = (mrd == mwr);
  assign meta_rd_data = mmem[mrd[7:0]];
  assign data_empty   = (drd == dwr) || hold_empty;
  assign data_rd_data = dmem[drd[9:0]];

  always @(posedge clock) begin
    if (flush) begin
      mrd <= mwr;
      drd <= dwr;
    end else begin
      if (meta_rd_en) mrd <= mrd + 1;
      if (data_rd_en) begin
        drd  <= drd + 1;
        pops <= pops + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [BV-1:0] exp_q[$];
  int            beat_cnt = 0;
  logic          stall_prev = 1'b0;
  logic [BV-1:0] prev_vec;
  logic [BV-1:0] cur_vec;
  logic [BV-1:0] exp_beat;

  always @(negedge clock) begin
    cur_vec = {m_tdata, m_tkeep, m_tlast, m_tuser};
    if (flush) exp_q.delete();
    if (data_rd_en) chk("data_pop_while_empty", data_empty === 1'b0);
    if (meta_rd_en) chk("meta_pop_while_empty", meta_empty === 1'b0);
    if (stall_prev && resetn) begin
      chk("stall_valid_held", m_tvalid === 1'b1);
      chk("stall_beat_stable", cur_vec === prev_vec);
    end
    if (resetn && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", exp_q.size() != 0);
      end else begin
        exp_beat = exp_q.pop_front();
        chk("beat", cur_vec === exp_beat);
      end
      beat_cnt++;
    end
    stall_prev = resetn && m_tvalid && !m_tready;
    prev_vec   = cur_vec;
  end

  // ---------------- driver tasks ----------------
  // Data byte j of word i is tag + 4*i + j. keep on the final beat is
  // looked up from the tail length by hand.
  task automatic push_frame(input int len, input logic [UW-1:0] st, input logic [7:0] tag);
    int nw;
    int rem;
    logic [DW-1:0] w;
    logic [3:0]    k;
    logic          l;
    nw  = (len + 3) / 4;
    rem = len % 4;
    for (int i = 0; i < nw; i++) begin
      for (int b = 0; b < 4; b++) w[8*b +: 8] = tag + 8'(4 * i + b);
      dmem[dwr[9:0]] = w;
      dwr++;
      l = (i == nw - 1);
      k = 4'hF;
      if (l) begin
        case (rem)
          1:       k = 4'h1;
          2:       k = 4'h3;
          3:       k = 4'h7;
          default: k = 4'hF;
        endcase
      end
      exp_q.push_back({w, k, l, st});
    end
    mmem[mwr[7:0]] = {st, 13'(len)};
    mwr++;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || mrd != mwr) && t < 3000) begin
      @(negedge clock);
      t++;
    end
    chk("drain_timeout", t < 3000);
    repeat (3) @(negedge clock);
  endtask

  // ---------------- directed sequence ----------------
  int t, b0, p0, p1;
  logic [31:0] sf0, sb0;

  initial begin
    sf0 = '0;
    sb0 = '0;
    repeat (2) @(posedge clock);
    // A 64-byte frame waits while reset is held; nothing may be popped.
    push_frame(64, 19'h12345, 8'h00);
    @(negedge clock);
    chk("rst_tvalid", m_tvalid === 1'b0);
    chk("rst_tlast", m_tlast === 1'b0);
    chk("rst_meta_rd_en", meta_rd_en === 1'b0);
    chk("rst_data_rd_en", data_rd_en === 1'b0);
    chk("rst_tdata", m_tdata === 32'h0);
    chk("rst_tkeep", m_tkeep === 4'h0);
    chk("rst_tuser", m_tuser === 19'h0);
`ifdef PRISM_SP_RX_READER_STATS_EN
    chk("rst_nframes", stats_nframes === 32'h0);
    chk("rst_nbytes", stats_nbytes === 32'h0);
    chk("rst_nzero", stats_nzero === 32'h0);
`endif
    @(posedge clock);
    #1 resetn = 1'b1;

    // 64 bytes, tready=1: latency 3, 16 back-to-back beats, 16 pops.
    t = 0;
    do begin @(negedge clock); t++; end while (!meta_rd_en && t < 20);
    chk("meta_pop_seen", meta_rd_en === 1'b1);
    t = 0;
    do begin @(negedge clock); t++; end while (!m_tvalid && t < 20);
    chk("first_beat_latency", t == 3);
    t = 0;
    while (!(m_tvalid && m_tready && m_tlast) && t < 40) begin
      @(negedge clock);
      t++;
    end
    chk("burst_cycles", t == 15);
    wait_drain();
    chk("f64_beats", beat_cnt == 16);
    chk("f64_pops", pops == 16);

    // 61 bytes: 16 beats, last keep 4'h1.
    b0 = beat_cnt; p0 = pops;
    push_frame(61, 19'h00A5A, 8'h40);
    wait_drain();
    chk("f61_beats", beat_cnt - b0 == 16);
    chk("f61_pops", pops - p0 == 16);

    // 0 bytes then 4 bytes.
    b0 = beat_cnt; p0 = pops;
    push_frame(0, 19'h7FFFF, 8'h80);
    push_frame(4, 19'h00001, 8'h90);
    wait_drain();
    chk("z4_beats", beat_cnt - b0 == 1);
    chk("z4_pops", pops - p0 == 1);
    chk("z4_meta_drained", mrd == mwr);
`ifdef PRISM_SP_RX_READER_STATS_EN
    chk("z4_nzero", stats_nzero === 32'd1);
    sf0 = stats_nframes;
    sb0 = stats_nbytes;
`endif

    // 8 x 60 bytes with tready toggling every cycle.
    b0 = beat_cnt;
    for (int f = 0; f < 8; f++) push_frame(60, 19'(100 + 37 * f), 8'(16 * f + 3));
    t = 0;
    while ((exp_q.size() != 0 || mrd != mwr) && t < 2000) begin
      @(posedge clock);
      #1 m_tready = ~m_tready;
      t++;
    end
    chk("toggle_timeout", t < 2000);
    @(posedge clock);
    #1 m_tready = 1'b1;
    wait_drain();
    chk("toggle_beats", beat_cnt - b0 == 120);
`ifdef PRISM_SP_RX_READER_STATS_EN
    chk("toggle_nframes", stats_nframes - sf0 === 32'd8);
    chk("toggle_nbytes", stats_nbytes - sb0 === 32'd480);
`endif

    // 64 bytes with the data FIFO forced empty for 5 cycles after beat 3.
    b0 = beat_cnt; p0 = pops;
    push_frame(64, 19'h0BEEF, 8'hC0);
    t = 0;
    while (beat_cnt - b0 < 3 && t < 40) begin
      @(negedge clock);
      t++;
    end
    @(posedge clock);
    #1 hold_empty = 1'b1;
    p1 = pops;
    repeat (5) begin
      @(negedge clock);
      chk("stall_no_pop", data_rd_en === 1'b0);
    end
    chk("stall_pop_count", pops == p1);
    @(posedge clock);
    #1 hold_empty = 1'b0;
    wait_drain();
    chk("stall_beats", beat_cnt - b0 == 16);
    chk("stall_pops", pops - p0 == 16);

    // Reset while beat 5 of a frame is on the bus.
    b0 = beat_cnt;
    push_frame(64, 19'h00777, 8'hE0);
    t = 0;
    while (beat_cnt - b0 < 4 && t < 40) begin
      @(negedge clock);
      t++;
    end
    @(posedge clock);
    #1 resetn = 1'b0;
    flush = 1'b1;
    #1;
    chk("midrst_tvalid", m_tvalid === 1'b0);
    chk("midrst_data_rd_en", data_rd_en === 1'b0);
    chk("midrst_meta_rd_en", meta_rd_en === 1'b0);
`ifdef PRISM_SP_RX_READER_STATS_EN
    chk("midrst_nframes", stats_nframes === 32'h0);
`endif
    @(posedge clock);
    #1 flush = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #1 resetn = 1'b1;
    b0 = beat_cnt;
    push_frame(8, 19'h4321A, 8'h55);
    wait_drain();
    chk("post_rst_beats", beat_cnt - b0 == 2);
`ifdef PRISM_SP_RX_READER_STATS_EN
    chk("post_rst_nframes", stats_nframes === 32'd1);
    chk("post_rst_nbytes", stats_nbytes === 32'd8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
